// File: rtl/axi_rab_pkg.sv
// axi_rab_pkg: shared R-error-sender FSM state encoding and RRESP constant.
//   ST_IDLE / ST_FWD / ST_ERR  : sender FSM states
//   RRESP_SLVERR               : response code driven on synthesized error beats
package axi_rab_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    localparam logic [1:0] RRESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi4_drop_fifo.sv
// axi4_drop_fifo: pending-drop FIFO holding {id, len, user} of dropped AR requests.
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_push, i_din    : write strobe and entry (ignored when full)
//   i_pop            : remove head entry (ignored when empty)
//   o_dout           : head entry, valid while !o_empty
//   o_full, o_empty  : status from registered occupancy
module axi4_drop_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    // Full/empty come only from registered occupancy, so a pop in the same
    // cycle never opens a slot for a push while full.
    assign o_full  = r_cnt == (AW+1)'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_dout  = r_mem[r_rd];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            r_wr  <= w_push ? r_wr + 1'b1 : r_wr;
            r_rd  <= w_pop ? r_rd + 1'b1 : r_rd;
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr] <= i_din;
    end

endmodule

// File: rtl/axi4_r_err_sender.sv
// axi4_r_err_sender: merges downstream R traffic with SLVERR bursts for dropped ARs.
//   axi4_aclk, axi4_arstn        : clock, asynchronous active-low reset
//   drop_*                       : dropped-AR queue input (valid/ready, id, len, user)
//   m_axi4_r*                    : R channel from downstream slave (m_axi4_rready out)
//   s_axi4_r*                    : R channel to upstream master (s_axi4_rready in)
//   err_cnt                      : completed error bursts, saturating (only with RAB_R_ERR_CNT_EN)
import axi_rab_pkg::*;

module axi4_r_err_sender #(
    parameter int C_AXI_ID_WIDTH    = 4,
    parameter int C_AXI_USER_WIDTH  = 4,
    parameter int C_AXI_DATA_WIDTH  = 64,
    parameter int C_DROP_FIFO_DEPTH = 4
) (
    input  logic                        axi4_aclk,
    input  logic                        axi4_arstn,
    input  logic                        drop_valid,
    output logic                        drop_ready,
    input  logic [C_AXI_ID_WIDTH-1:0]   drop_id,
    input  logic [7:0]                  drop_len,
    input  logic [C_AXI_USER_WIDTH-1:0] drop_user,
    input  logic [C_AXI_ID_WIDTH-1:0]   m_axi4_rid,
    input  logic [C_AXI_DATA_WIDTH-1:0] m_axi4_rdata,
    input  logic [1:0]                  m_axi4_rresp,
    input  logic                        m_axi4_rlast,
    input  logic [C_AXI_USER_WIDTH-1:0] m_axi4_ruser,
    input  logic                        m_axi4_rvalid,
    output logic                        m_axi4_rready,
    output logic [C_AXI_ID_WIDTH-1:0]   s_axi4_rid,
    output logic [C_AXI_DATA_WIDTH-1:0] s_axi4_rdata,
    output logic [1:0]                  s_axi4_rresp,
    output logic                        s_axi4_rlast,
    output logic [C_AXI_USER_WIDTH-1:0] s_axi4_ruser,
    output logic                        s_axi4_rvalid,
    input  logic                        s_axi4_rready
`ifdef RAB_R_ERR_CNT_EN
    ,
    output logic [31:0]                 err_cnt
`endif
);

    localparam int EW = C_AXI_ID_WIDTH + 8 + C_AXI_USER_WIDTH;

    state_t                      r_state;
    state_t                      w_next;
    logic [7:0]                  r_cnt;
    logic                        r_last_err;
    logic                        w_full;
    logic                        w_empty;
    logic [EW-1:0]               w_head;
    logic [C_AXI_ID_WIDTH-1:0]   w_head_id;
    logic [7:0]                  w_head_len;
    logic [C_AXI_USER_WIDTH-1:0] w_head_user;
    logic                        w_err_last;
    logic                        w_err_hs;
    logic                        w_err_done;
    logic                        w_fwd_done;

    // Gated by reset so the queue looks unavailable while reset is held.
    assign drop_ready = axi4_arstn & ~w_full;

    axi4_drop_fifo #(
        .W     (EW),
        .DEPTH (C_DROP_FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (axi4_aclk),
        .i_rst_n (axi4_arstn),
        .i_push  (drop_valid & drop_ready),
        .i_din   ({drop_id, drop_len, drop_user}),
        .i_pop   (w_err_done),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign {w_head_id, w_head_len, w_head_user} = w_head;

    // The head entry stays in the FIFO for the whole burst, so the error
    // payload is stable until the final handshake pops it.
    assign w_err_last = r_cnt == w_head_len;
    assign w_err_hs   = (r_state == ST_ERR) & s_axi4_rready;
    assign w_err_done = w_err_hs & w_err_last;
    assign w_fwd_done = (r_state == ST_FWD) & m_axi4_rvalid & s_axi4_rready & m_axi4_rlast;

    always_comb begin
        w_next        = r_state;
        m_axi4_rready = 1'b0;
        s_axi4_rvalid = 1'b0;
        s_axi4_rid    = '0;
        s_axi4_rdata  = '0;
        s_axi4_rresp  = '0;
        s_axi4_rlast  = 1'b0;
        s_axi4_ruser  = '0;
        case (r_state)
            ST_IDLE: begin
                // Both pending: serve the source that did not go last.
                if (!w_empty && m_axi4_rvalid) w_next = r_last_err ? ST_FWD : ST_ERR;
                else if (!w_empty)             w_next = ST_ERR;
                else if (m_axi4_rvalid)        w_next = ST_FWD;
            end
            ST_FWD: begin
                m_axi4_rready = s_axi4_rready;
                s_axi4_rvalid = m_axi4_rvalid;
                s_axi4_rid    = m_axi4_rid;
                s_axi4_rdata  = m_axi4_rdata;
                s_axi4_rresp  = m_axi4_rresp;
                s_axi4_rlast  = m_axi4_rlast;
                s_axi4_ruser  = m_axi4_ruser;
                w_next        = w_fwd_done ? ST_IDLE : ST_FWD;
            end
            ST_ERR: begin
                s_axi4_rvalid = 1'b1;
                s_axi4_rid    = w_head_id;
                s_axi4_rresp  = RRESP_SLVERR;
                s_axi4_rlast  = w_err_last;
                s_axi4_ruser  = w_head_user;
                w_next        = w_err_done ? ST_IDLE : ST_ERR;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_last_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_err_done) begin
                r_cnt      <= '0;
                r_last_err <= 1'b1;
            end else if (w_err_hs) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_fwd_done) r_last_err <= 1'b0;
        end
    end

`ifdef RAB_R_ERR_CNT_EN
    logic [31:0] r_err_cnt;

    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn)                      r_err_cnt <= '0;
        else if (w_err_done && ~&r_err_cnt)   r_err_cnt <= r_err_cnt + 32'd1;
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: doc/axi4_r_err_sender.md
AXI4_R_ERR_SENDER -- requirements
Module: axi4_r_err_sender

Interface
REQ-001 SHALL have parameter C_AXI_ID_WIDTH, default 4, R/drop ID width.
REQ-002 SHALL have parameter C_AXI_USER_WIDTH, default 4, R/drop user width.
REQ-003 SHALL have parameter C_AXI_DATA_WIDTH, default 64, R data width.
REQ-004 SHALL have parameter C_DROP_FIFO_DEPTH, default 4, pending-drop FIFO entries, power of 2, at least 2.
REQ-005 SHALL have one clock and an asynchronous active-low reset; ports: axi4_aclk in 1 clock; axi4_arstn in 1 reset.
REQ-006 SHALL have ports: drop_valid in 1, dropped AR present; drop_ready out 1, FIFO can accept; drop_id in ID, dropped ARID; drop_len in 8, dropped ARLEN; drop_user in USER, dropped ARUSER.
REQ-007 SHALL have ports: m_axi4_rid/rdata/rresp/rlast/ruser/rvalid in (widths ID/DATA/2/1/USER/1), downstream slave R; m_axi4_rready out 1.
REQ-008 SHALL have ports: s_axi4_rid/rdata/rresp/rlast/ruser/rvalid out (same widths), R to upstream master; s_axi4_rready in 1.

Function
REQ-009 SHALL push {drop_id, drop_len, drop_user} into the FIFO on a drop_valid & drop_ready cycle.
REQ-010 SHALL drive drop_ready = not full, from registered occupancy; a same-cycle pop SHALL NOT enable a push when full.
REQ-011 SHALL use FSM states IDLE, FWD and ERR.
REQ-012 In IDLE, SHALL drive s_axi4_rvalid=0 and m_axi4_rready=0.
REQ-013 In IDLE, SHALL go to ERR if only the FIFO is non-empty, to FWD if only m_axi4_rvalid=1, and stay otherwise.
REQ-014 In IDLE with both pending, SHALL pick opposite to the last served source (last_err flag, reset 0, so ERR wins first).
REQ-015 In FWD, SHALL pass s_axi4_r* = m_axi4_r* and m_axi4_rready = s_axi4_rready combinationally, with zero latency.
REQ-016 In FWD, SHALL return to IDLE on a handshake with m_axi4_rlast=1 and clear last_err.
REQ-017 In ERR, SHALL hold m_axi4_rready=0 and drive s_axi4_rvalid=1, rid/ruser from the FIFO head, rdata=0, and rresp=2'b10 (SLVERR).
REQ-018 In ERR, SHALL count beats with an 8-bit counter that starts at 0 and increments per s-side handshake.
REQ-019 In ERR, SHALL assert s_axi4_rlast when count==drop_len, giving drop_len+1 beats (drop_len=255 gives 256 beats, with no counter overflow use).
REQ-020 On the last ERR handshake, SHALL pop the FIFO, zero the counter, set last_err and go to IDLE.
REQ-021 SHALL never deassert s_axi4_rvalid, or change s-side payload, before its handshake.
REQ-022 A drop pushed during FWD or ERR SHALL wait, and SHALL never interleave within a burst.

Reset
REQ-023 On axi4_arstn=0, SHALL immediately force: state IDLE, FIFO empty, counter 0, last_err 0, s_axi4_rvalid=0, m_axi4_rready=0, drop_ready=0 while asserted.
REQ-024 After reset, drop_ready SHALL be 1; a reset mid-burst SHALL discard the burst and queued drops.

Configuration
REQ-025 With RAB_R_ERR_CNT_EN defined, SHALL add output err_cnt [31:0], reset 0, incremented per completed ERR burst and saturating at 0xFFFFFFFF.
REQ-026 Without RAB_R_ERR_CNT_EN, the port and counter SHALL be absent, with identical remaining behaviour.

Structure
REQ-027 SHALL put FSM state encoding and the RRESP constant (SLVERR=2'b10) in shared package axi_rab_pkg.
REQ-028 SHALL implement the FIFO as sub-module axi4_drop_fifo: push/pop, full/empty, entry width ID+8+USER.

Verification
REQ-029 Drop id=3 len=3, no master R, s_rready=1: SHALL give 4 beats rid=3 rresp=2'b10 rdata=0, rlast on beat 4, then drop_ready=1.
REQ-030 Master burst rid=5 of 2 beats, s_rready toggling 1/0: SHALL forward both beats unchanged with m_rready==s_rready, and return to IDLE after rlast.
REQ-031 Drop id=1 len=0 queued while m_rvalid=1 in IDLE after reset: SHALL send the ERR single beat first, then the master burst.
REQ-032 Push 4 drops with s_rready=0: SHALL hold drop_ready=0 after the 4th, the 5th is not accepted, and s-side payload holds stable until ready.
REQ-033 Assert axi4_arstn=0 on ERR beat 2 of len=7: SHALL immediately drop s_rvalid to 0, empty the FIFO and emit no further beats after release.
REQ-034 Drop len=255 with RAB_R_ERR_CNT_EN defined: SHALL give 256 beats with rlast only on the last, and err_cnt 0->1.
